// File: rtl/count_packer.sv
// count_packer: packs LANES consecutive 16-bit count samples into one word.
// Optional partial-word flush enabled by defining COUNT_PACKER_FLUSH_EN.
module count_packer #(
  parameter int LANES   = 2,
  parameter int COUNT_W = 16,
  parameter int SEQ_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef COUNT_PACKER_FLUSH_EN
  input  logic                     flush,
  output logic                     out_partial,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COUNT_W-1:0]       in_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COUNT_W-1:0] out_data,
  output logic [SEQ_W-1:0]         out_seq
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACC_W = (LANES - 1) * COUNT_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]         lane_q, lane_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ov_q, ov_d;
  logic [LANES*COUNT_W-1:0] data_q, data_d;
  logic [SEQ_W-1:0]         seq_q, seq_d;
  logic                     last, accept, xfer;
  logic                     flush_hold, flush_go;

`ifdef COUNT_PACKER_FLUSH_EN
  logic part_q, part_d;
  assign flush_hold = flush;
  assign flush_go   = flush && (lane_q != '0) && (!ov_q || out_ready);
  assign out_partial = part_q;
`else
  assign flush_hold = 1'b0;
  assign flush_go   = 1'b0;
`endif

  assign last      = (lane_q == LAST);
  assign in_ready  = (!last || !ov_q || out_ready) && !flush_hold;
  assign accept    = in_valid && in_ready;
  assign xfer      = ov_q && out_ready;
  assign out_valid = ov_q;
  assign out_data  = data_q;
  assign out_seq   = seq_q;

  // Next-state: lane collection, output slot load/drain, word counter.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    ov_d   = ov_q;
    data_d = data_q;
    seq_d  = seq_q;
`ifdef COUNT_PACKER_FLUSH_EN
    part_d = part_q;
`endif
    if (xfer) begin
      ov_d  = 1'b0;
      seq_d = seq_q + SEQ_W'(1);
    end
    if (flush_go) begin
      data_d = {{COUNT_W{1'b0}}, acc_q};
      ov_d   = 1'b1;
      lane_d = '0;
      acc_d  = '0;
`ifdef COUNT_PACKER_FLUSH_EN
      part_d = 1'b1;
`endif
    end else if (accept) begin
      if (last) begin
        data_d = {in_count, acc_q};
        ov_d   = 1'b1;
        lane_d = '0;
        acc_d  = '0;
`ifdef COUNT_PACKER_FLUSH_EN
        part_d = 1'b0;
`endif
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (lane_q == IDX_W'(k)) begin
            acc_d[k*COUNT_W +: COUNT_W] = in_count;
          end
        end
        lane_d = lane_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      acc_q  <= '0;
      ov_q   <= 1'b0;
      data_q <= '0;
      seq_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
      ov_q   <= ov_d;
      data_q <= data_d;
      seq_q  <= seq_d;
    end
  end

`ifdef COUNT_PACKER_FLUSH_EN
  // Partial-word qualifier for out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) part_q <= 1'b0;
    else        part_q <= part_d;
  end
`endif

endmodule

// File: tb/tb_count_packer.sv
// tb_count_packer: directed vector bench for count_packer (LANES=2, SEQ_W=4).
// Flush checks are compiled when COUNT_PACKER_FLUSH_EN is defined.
module tb_count_packer;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_count = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [SW-1:0] out_seq;
  logic        flush = 1'b0;
  logic        out_partial;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_packer #(.LANES(2), .COUNT_W(16), .SEQ_W(SW)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef COUNT_PACKER_FLUSH_EN
    .flush(flush),
    .out_partial(out_partial),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_count(in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_seq(out_seq)
  );

`ifndef COUNT_PACKER_FLUSH_EN
  assign out_partial = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [15:0] ic;
    logic        ordy;
    logic        irdy;
    logic        ov;
    logic [31:0] data;
    logic [SW-1:0] seq;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ic,
                       input logic ordy);
    in_valid  = iv;
    in_count  = ic;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic vec_t mk(logic iv, logic [15:0] ic, logic ordy,
                              logic irdy, logic ov, logic [31:0] d,
                              logic [SW-1:0] s);
    vec_t v;
    v.iv = iv; v.ic = ic; v.ordy = ordy; v.irdy = irdy;
    v.ov = ov; v.data = d; v.seq = s;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 16'h1234, 1, 1, 0, 32'h0000_0000, 0);
    tbl[1]  = mk(1, 16'hABCD, 1, 1, 1, 32'hABCD_1234, 0);
    tbl[2]  = mk(0, 16'h0000, 1, 1, 0, 32'hABCD_1234, 1);
    tbl[3]  = mk(1, 16'h0001, 1, 1, 0, 32'hABCD_1234, 1);
    tbl[4]  = mk(1, 16'h0002, 1, 1, 1, 32'h0002_0001, 1);
    tbl[5]  = mk(1, 16'h0003, 1, 1, 0, 32'h0002_0001, 2);
    tbl[6]  = mk(1, 16'h0004, 1, 1, 1, 32'h0004_0003, 2);
    tbl[7]  = mk(1, 16'h0005, 1, 1, 0, 32'h0004_0003, 3);
    tbl[8]  = mk(1, 16'h0006, 1, 1, 1, 32'h0006_0005, 3);
    tbl[9]  = mk(0, 16'h0000, 1, 1, 0, 32'h0006_0005, 4);
    tbl[10] = mk(1, 16'h0011, 0, 1, 0, 32'h0006_0005, 4);
    tbl[11] = mk(1, 16'h0022, 0, 1, 1, 32'h0022_0011, 4);
    tbl[12] = mk(1, 16'h0033, 0, 1, 1, 32'h0022_0011, 4);
    tbl[13] = mk(1, 16'h0044, 0, 0, 1, 32'h0022_0011, 4);
    tbl[14] = mk(1, 16'h0044, 1, 1, 1, 32'h0044_0033, 5);
    tbl[15] = mk(0, 16'h0000, 1, 1, 0, 32'h0044_0033, 6);

    // Reset state
    rst_n = 1'b0;
    #2;
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_seq", 32'(out_seq), 32'h0);
    chk("rst_part", 32'(out_partial), 32'h0);
    do_reset();
    chk("rst_irdy", 32'(in_ready), 32'h1);

    // Table: basic pair, streaming, backpressure
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].ic, tbl[i].ordy);
      chk($sformatf("v%0d_irdy", i), 32'(in_ready), 32'(tbl[i].irdy));
      tick();
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_data", i), out_data, tbl[i].data);
      chk($sformatf("v%0d_seq", i), 32'(out_seq), 32'(tbl[i].seq));
    end

    // Async reset mid-word with a full slot
    drive(1'b1, 16'h0101, 1'b0);
    tick();
    drive(1'b1, 16'h0202, 1'b0);
    tick();
    drive(1'b1, 16'h5555, 1'b0);
    tick();
    chk("ar_pre_ov", 32'(out_valid), 32'h1);
    drive(1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'h0);
    chk("ar_data", out_data, 32'h0);
    chk("ar_seq", 32'(out_seq), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 16'h0007, 1'b1);
    tick();
    chk("ar_lane0_ov", 32'(out_valid), 32'h0);
    drive(1'b1, 16'h0008, 1'b1);
    tick();
    chk("ar_word_ov", 32'(out_valid), 32'h1);
    chk("ar_word", out_data, 32'h0008_0007);
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk("ar_seq1", 32'(out_seq), 32'h1);

    // Sequence counter wrap over 17 words
    do_reset();
    for (int w = 0; w < 17; w++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'(2 * w);
      b = 16'(2 * w + 1);
      drive(1'b1, a, 1'b1);
      tick();
      drive(1'b1, b, 1'b1);
      tick();
      chk($sformatf("wrap%0d_data", w), out_data, {b, a});
      chk($sformatf("wrap%0d_seq", w), 32'(out_seq), 32'(w % 16));
    end
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk("wrap_end_seq", 32'(out_seq), 32'h1);
    chk("wrap_end_ov", 32'(out_valid), 32'h0);

`ifdef COUNT_PACKER_FLUSH_EN
    // Partial flush, priority over sample, no-op at lane 0
    do_reset();
    drive(1'b1, 16'h00FF, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 1'b0);
    chk("fl_irdy", 32'(in_ready), 32'h0);
    tick();
    chk("fl_ov", 32'(out_valid), 32'h1);
    chk("fl_data", out_data, 32'h0000_00FF);
    chk("fl_part", 32'(out_partial), 32'h1);
    flush = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    tick();
    chk("fl_drain", 32'(out_valid), 32'h0);
    flush = 1'b1;
    drive(1'b0, 16'h0, 1'b1);
    tick();
    tick();
    chk("fl_noop_ov", 32'(out_valid), 32'h0);
    chk("fl_noop_seq", 32'(out_seq), 32'h1);
    flush = 1'b0;
    drive(1'b1, 16'h0A0A, 1'b1);
    tick();
    drive(1'b1, 16'h0B0B, 1'b1);
    tick();
    chk("fl_full_data", out_data, 32'h0B0B_0A0A);
    chk("fl_full_part", 32'(out_partial), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_packer.md
Name: count_packer

Overview:
- Stream packer feeding the packed-count consumer stage.
- Accepts one 16-bit count sample per valid/ready handshake and concatenates LANES consecutive samples into one packed word (lane 0 in LSBs).
- Emits the packed word through a single registered output slot with valid/ready backpressure.
- Also maintains a free-running count of emitted words.

Parameters:
- LANES, 2, samples per packed word; legal range 2..8.
- COUNT_W, 16, width of one count sample in bits.
- SEQ_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present on in_count.
- in_ready  output  1  block accepts sample this cycle.
- in_count  input  COUNT_W  count sample.
- out_valid  output  1  packed word held in output slot.
- out_ready  input  1  consumer takes word this cycle.
- out_data  output  LANES*COUNT_W  packed word; lane k at bits [k*COUNT_W +: COUNT_W].
- out_seq  output  SEQ_W  number of words emitted so far, modulo 2^SEQ_W.

Behaviour:
- Reset, asynchronous on rst_n low:
  - lane_idx=0, accumulator=0.
  - out_valid=0, out_data=0, out_seq=0.
  - in_ready is 1 one cycle after release.
- State is lane_idx, 0..LANES-1 (COLLECT_0..COLLECT_{LANES-1}).
- Handshakes:
  - Accept happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- in_ready = (lane_idx != LANES-1) || !out_valid || out_ready. It is combinational from out_ready and registered state only, never from in_valid.
- Accept with lane_idx < LANES-1:
  - in_count is stored in accumulator lane lane_idx.
  - lane_idx increments.
- Accept with lane_idx == LANES-1:
  - out_data <= {in_count, accumulator lanes LANES-2..0}.
  - out_valid <= 1, lane_idx <= 0, accumulator cleared.
- Output transfer with no new word completing: out_valid <= 0; out_data holds its last value.
- Output transfer in the same cycle a new word completes: out_valid stays 1 and out_data takes the new word. Full throughput is one sample per cycle.
- out_seq increments by 1 on each output transfer and wraps 2^SEQ_W-1 -> 0.
- Latency: the last lane accepted at edge N gives out_valid=1 after edge N.
- Holding rules:
  - in_count is sampled only on accept.
  - out_data and out_valid are stable while out_valid && !out_ready.
- Backpressure only stalls the final lane. Earlier lanes continue accumulating while the output slot is full.
- Reset mid-word: the partial accumulator is discarded and no word is emitted.

Optional Feature:
- Macro: COUNT_PACKER_FLUSH_EN.
- With macro defined, two ports are added:
  - flush  input 1: request emission of a partial word.
  - out_partial  output 1: qualifies out_data; reset 0.
- Flush is taken when flush && lane_idx != 0 && (!out_valid || out_ready):
  - out_data = accumulated lanes, unused upper lanes zero.
  - out_partial <= 1, out_valid <= 1, lane_idx <= 0.
- While flush is high, in_ready=0. Flush has priority over a simultaneous sample, and that sample is not accepted.
- Flush with lane_idx==0 is a no-op.
- Flush while the slot is full and out_ready=0 waits; it is held by the requester.
- A full word sets out_partial <= 0.
- Without the macro: no flush or out_partial ports, and the logic is absent.

Test Plan:
- Reset then samples 0x1234, 0xABCD, out_ready=1 -> out_valid=1 one cycle after second accept; out_data=0xABCD1234; out_seq 0->1 on transfer.
- Continuous in_valid with 6 samples 0x0001..0x0006, out_ready=1 -> words 0x00020001, 0x00040003, 0x00060005 on consecutive pairs; in_ready never drops; out_seq=3.
- out_ready=0 with 4 samples offered -> first word held stable; in_ready=1 for the 3rd sample, in_ready=0 for the 4th; raising out_ready -> 4th accepted same cycle, second word replaces first with out_valid staying 1.
- Assert rst_n=0 asynchronously after one sample 0x5555 -> out_valid=0 immediately; the next two samples 0x0007, 0x0008 produce 0x00080007.
- out_seq wrap: SEQ_W=4, 17 words transferred -> out_seq sequence reaches 15 then 0, then 1.
- With COUNT_PACKER_FLUSH_EN: one sample 0x00FF then flush=1 -> out_data=0x000000FF, out_partial=1, in_ready=0 during flush; flush with lane_idx=0 -> no output.
